pack_input_arbiter: RTL and testbench

Packet-granular round-robin arbiter between NUM_SRC byte-stream requesters and the single byte input of the packetizer (ping-pong packet buffer with preamble slot and idle-packet insertion). Once a source wins, it owns the packetizer input for exactly one payload of PAYLOAD_BYTES bytes, so payloads from different sources never interleave inside one packet. A stalled owner can optionally be timed out, with the rest of its payload filled with PAD_BYTE.

---
 rtl/pack_input_arbiter_if.sv | 26 ++
 rtl/pack_input_arbiter.sv | 179 +++++++++++++++++
 tb/tb_pack_input_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pack_input_arbiter_if.sv
// Byte-stream bundle between NUM_SRC requesters, the packet arbiter and the packetizer input.
// The slave modport is the arbiter's view; the master modport drives sources and downstream ready.
interface pack_input_arbiter_if #(
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned SIZE_INPUT_BIT = 8
);
  logic [NUM_SRC*SIZE_INPUT_BIT-1:0] i_data;
  logic [NUM_SRC-1:0]                i_valid;
  logic [NUM_SRC-1:0]                o_ready;
  logic [SIZE_INPUT_BIT-1:0]         o_data;
  logic                              o_valid;
  logic                              i_ready;
  logic [NUM_SRC-1:0]                o_grant;
  logic                              o_pkt_done;
  logic                              o_padded;

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_grant, o_pkt_done, o_padded
  );

  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_grant, o_pkt_done, o_padded
  );
endinterface

// File: rtl/pack_input_arbiter.sv
// Packet-granular round-robin arbiter: a winning source owns the packetizer input for one full payload.
// Define PACK_ARB_TIMEOUT_PAD_EN to time out a stalled owner and fill its payload with PAD_BYTE.
module pack_input_arbiter #(
  parameter int unsigned              NUM_SRC        = 2,
  parameter int unsigned              SIZE_INPUT_BIT = 8,
  parameter int unsigned              PAYLOAD_BYTES  = 243,
  parameter int unsigned              TIMEOUT_CYCLES = 1024,
  parameter logic [SIZE_INPUT_BIT-1:0] PAD_BYTE      = '0
) (
  input logic                  i_clk,
  input logic                  i_reset,
  pack_input_arbiter_if.slave  bus
);

  localparam int unsigned SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CAND_W = SRC_W + 1;
  localparam int unsigned CNT_W  = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

`ifdef PACK_ARB_TIMEOUT_PAD_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_PAD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_STREAM} state_t;
`endif

  state_t                    state_q, state_d;
  logic [NUM_SRC-1:0]        grant_q, grant_d;
  logic [SRC_W-1:0]          owner_q, owner_d;
  logic [SRC_W-1:0]          ptr_q, ptr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      done_q, done_d;
`ifdef PACK_ARB_TIMEOUT_PAD_EN
  logic [TMO_W-1:0]          tmo_q, tmo_d;
  logic                      padded_q, padded_d;
`endif

  logic [SIZE_INPUT_BIT-1:0] data_c;
  logic                      valid_c;
  logic [NUM_SRC-1:0]        ready_c;
  logic                      xfer_c;
  logic                      last_c;
  logic [SIZE_INPUT_BIT-1:0] owner_byte;
  logic                      owner_valid;
  logic                      found;
  logic [SRC_W-1:0]          win;
  logic [CAND_W-1:0]         cand;

  // State register with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
`ifdef PACK_ARB_TIMEOUT_PAD_EN
      tmo_q    <= '0;
      padded_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
`ifdef PACK_ARB_TIMEOUT_PAD_EN
      tmo_q    <= tmo_d;
      padded_q <= padded_d;
`endif
    end
  end

  // Next-state, arbitration and combinational data path
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
`ifdef PACK_ARB_TIMEOUT_PAD_EN
    tmo_d       = tmo_q;
    padded_d    = 1'b0;
`endif
    data_c      = '0;
    valid_c     = 1'b0;
    ready_c     = '0;
    found       = 1'b0;
    win         = '0;
    cand        = '0;
    owner_byte  = '0;
    owner_valid = 1'b0;

    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (owner_q == SRC_W'(k)) begin
        owner_byte  = bus.i_data[k*SIZE_INPUT_BIT +: SIZE_INPUT_BIT];
        owner_valid = bus.i_valid[k];
      end
    end
    last_c = (cnt_q == CNT_W'(PAYLOAD_BYTES - 1));

    case (state_q)
      S_IDLE: begin
        // First requester at or after ptr, wrapping
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          cand = {1'b0, ptr_q} + CAND_W'(i);
          if (cand >= CAND_W'(NUM_SRC)) cand = cand - CAND_W'(NUM_SRC);
          for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!found && bus.i_valid[k] && (cand == CAND_W'(k))) begin
              found = 1'b1;
              win   = SRC_W'(k);
            end
          end
        end
        if (found) begin
          state_d = S_STREAM;
          grant_d = NUM_SRC'(1) << win;
          owner_d = win;
          cnt_d   = '0;
`ifdef PACK_ARB_TIMEOUT_PAD_EN
          tmo_d   = '0;
`endif
        end
      end
      S_STREAM: begin
        data_c  = owner_byte;
        valid_c = owner_valid;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
          ready_c[k] = (owner_q == SRC_W'(k)) && bus.i_ready;
        end
`ifdef PACK_ARB_TIMEOUT_PAD_EN
        // Only cycles the downstream could have accepted count as owner idle time
        if (bus.i_ready && !owner_valid) begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_d == TMO_W'(TIMEOUT_CYCLES)) state_d = S_PAD;
        end else if (owner_valid && bus.i_ready) begin
          tmo_d = '0;
        end
`endif
      end
`ifdef PACK_ARB_TIMEOUT_PAD_EN
      S_PAD: begin
        data_c  = PAD_BYTE;
        valid_c = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    xfer_c = valid_c && bus.i_ready;
    if (xfer_c) begin
      if (last_c) begin
        state_d = S_IDLE;
        grant_d = '0;
        done_d  = 1'b1;
        ptr_d   = (owner_q == SRC_W'(NUM_SRC - 1)) ? '0 : owner_q + SRC_W'(1);
`ifdef PACK_ARB_TIMEOUT_PAD_EN
        padded_d = (state_q == S_PAD);
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.o_data     = data_c;
  assign bus.o_valid    = valid_c;
  assign bus.o_ready    = ready_c;
  assign bus.o_grant    = grant_q;
  assign bus.o_pkt_done = done_q;
`ifdef PACK_ARB_TIMEOUT_PAD_EN
  assign bus.o_padded   = padded_q;
`else
  assign bus.o_padded   = 1'b0;
`endif

endmodule

// File: tb/tb_pack_input_arbiter.sv
// Bench for pack_input_arbiter: directed phases plus random traffic, checked every cycle
// against a payload-level reference model of ownership, byte count and idle time.
module tb_pack_input_arbiter;
  localparam int N = 2;
  localparam int W = 8;
  localparam int P = 4;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit checking = 1'b0;

  pack_input_arbiter_if #(.NUM_SRC(N), .SIZE_INPUT_BIT(W)) bus ();

  pack_input_arbiter #(
    .NUM_SRC(N), .SIZE_INPUT_BIT(W), .PAYLOAD_BYTES(P),
    .TIMEOUT_CYCLES(T), .PAD_BYTE(8'h00)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .bus(bus)
  );

  // Reference model: who owns the input, how many bytes it has sent, how long it idled
  int m_owner = -1;
  int m_ptr = 0;
  int m_cnt = 0;
  int m_idle = 0;
  bit m_pad = 1'b0;
  bit m_done = 1'b0;
  bit m_padded = 1'b0;
  int seq [N];

  logic [W-1:0] e_data;
  logic         e_valid;
  logic [N-1:0] e_ready;
  logic [N-1:0] e_grant;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [W-1:0] src_byte(input int k, input int s);
    return W'(((k + 1) << 4) + (s % 16));
  endfunction

  task automatic step(input logic [N-1:0] v, input bit r, input bit rst);
    bit xfer;
    bit found;
    int c;
    @(negedge clk);
    rst_n = rst;
    bus.i_valid = v;
    bus.i_ready = r;
    for (int k = 0; k < N; k++) bus.i_data[k*W +: W] = src_byte(k, seq[k]);
    #1;
    e_grant = '0;
    e_valid = 1'b0;
    e_data  = '0;
    e_ready = '0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      if (m_pad) begin
        e_valid = 1'b1;
      end else begin
        e_valid = v[m_owner];
        e_data  = src_byte(m_owner, seq[m_owner]);
        e_ready[m_owner] = r;
      end
    end
    if (checking) begin
      chk("grant",    32'(bus.o_grant),    32'(e_grant));
      chk("valid",    32'(bus.o_valid),    32'(e_valid));
      chk("data",     32'(bus.o_data),     32'(e_data));
      chk("ready",    32'(bus.o_ready),    32'(e_ready));
      chk("pkt_done", 32'(bus.o_pkt_done), 32'(m_done));
      chk("padded",   32'(bus.o_padded),   32'(m_padded));
    end
    @(posedge clk);
    if (!rst) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_idle = 0;
      m_pad = 1'b0; m_done = 1'b0; m_padded = 1'b0;
    end else begin
      xfer = e_valid && r;
      m_done = 1'b0;
      m_padded = 1'b0;
      if (m_owner < 0) begin
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          c = (m_ptr + i) % N;
          if (!found && v[c]) begin
            found = 1'b1;
            m_owner = c;
          end
        end
        m_cnt = 0; m_idle = 0; m_pad = 1'b0;
      end else if (xfer) begin
        if (!m_pad) seq[m_owner]++;
        m_idle = 0;
        if (m_cnt == P - 1) begin
          m_done = 1'b1;
          m_padded = m_pad;
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
          m_pad = 1'b0;
        end else begin
          m_cnt++;
        end
      end else if (r && !m_pad) begin
        m_idle++;
`ifdef PACK_ARB_TIMEOUT_PAD_EN
        if (m_idle == T) m_pad = 1'b1;
`endif
      end
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) seq[k] = 0;
    bus.i_valid = '0;
    bus.i_ready = 1'b0;
    bus.i_data  = '0;

    // Reset held with every source requesting
    step('1, 1'b1, 1'b0);
    checking = 1'b1;
    repeat (3) step('1, 1'b1, 1'b0);

    // Contention, then a 5-cycle downstream stall inside a payload
    repeat (30) step('1, 1'b1, 1'b1);
    repeat (3) step('1, 1'b1, 1'b1);
    repeat (5) step('1, 1'b0, 1'b1);
    repeat (20) step('1, 1'b1, 1'b1);
    repeat (40) step('1, 1'($urandom_range(0, 3) != 0), 1'b1);

    // Owner sends one byte then idles while src1 keeps requesting
    repeat (2) step('0, 1'b1, 1'b0);
    repeat (2) step(2'b01, 1'b1, 1'b1);
    repeat (120) step(2'b10, 1'b1, 1'b1);
    repeat (6) step(2'b01, 1'b1, 1'b1);
    repeat (20) step('1, 1'b1, 1'b1);

    // Random traffic with occasional mid-payload reset
    for (int n = 0; n < 400; n++) begin
      step(N'($urandom), 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 99) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
